modn_counter: RTL and testbench
===============================

Name: modn_counter

Overview:
- Parameterized modulo-N synchronous up-counter with count enable and terminal-count carry out.
- Instantiated with MODULUS=10 as the decade (units) digit and MODULUS=6 as the tens digit of seconds/minutes counters.
- Digit counters cascade by driving the next stage's en from the previous stage's co.

Parameters:
- MODULUS, 10, count range 0..MODULUS-1; legal range 2..2**WIDTH.
- WIDTH, 4, width of the count output in bits.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- en  input  1  count enable, sampled on rising clk.
- count  output  WIDTH  current count value, registered.
- co  output  1  carry out / terminal count, combinational.

Behaviour:
- Reset:
  - rst low forces count=0 immediately, independent of clk.
  - co then evaluates to 0, because count != MODULUS-1 (MODULUS>=2).
  - While rst is low, count stays 0 regardless of clk/en.
  - First count change after rst deasserts occurs on the first rising clk with en=1.
- Counting (rising clk, rst high):
  - en=1 and count<MODULUS-1: count <= count+1.
  - en=1 and count==MODULUS-1: count <= 0 (wrap).
  - en=0: count holds.
  - Latency: count reflects an enabled edge one clock after en is sampled, with no extra pipeline.
- Carry:
  - co = en AND (count == MODULUS-1), purely combinational.
  - co is high exactly during the cycle in which the next enabled edge wraps count to 0.
  - co is never high while en=0.
- Range rules:
  - count never takes values >= MODULUS in normal operation.
  - An out-of-range value, which can only arise from an X/upset, wraps to 0 on the next enabled edge.
  - co is not asserted for out-of-range values.
- Width and elaboration:
  - count is zero-extended to WIDTH.
  - Elaboration fails if MODULUS<2 or MODULUS>2**WIDTH.
- Reset mid-operation: asynchronous clear to 0 at any count. No pending carry survives the reset.
- Simultaneous rst low and rising clk with en=1: reset wins, count=0.
- Cascade (MODULUS 10 units, MODULUS 6 tens):
  - units.en = system en; tens.en = units.co.
  - Combined period is 60 enabled cycles.
  - Overall carry = tens.co, which is high only at units=9 and tens=5 with en=1.
- No initial blocks or wait statements; behaviour is fully defined by the reset.

Decomposition:
- Shared package holds:
  - constants DIGIT_W=4, MOD_DEC=10, MOD_SEX=6;
  - a function clog2 for deriving minimum width.
- No sub-module is needed.
- Six- and ten-state variants are instances of modn_counter with MODULUS=6 and MODULUS=10.
- A 0..59 counter is a separate wrapper that chains two instances via co->en.

Test Plan:
- Reset: rst=0 for 3 clks with en=1 -> count=0, co=0 throughout. Release rst at 1 -> count stays 0 until the first enabled edge.
- MODULUS=10 free run, en=1 for 12 clks:
  - count sequence 1,2,...,9,0,1,2;
  - co=1 only while count=9.
- Enable hold: count at 4, en=0 for 5 clks -> count stays 4, co=0. With count at 9 and en=0 -> co=0; raising en makes co=1 in the same cycle.
- MODULUS=6 instance, en=1 for 8 clks -> count 1,2,3,4,5,0,1,2; co=1 only while count=5.
- Async reset mid-count: count=7, rst pulsed low between clk edges -> count=0 immediately, before the next edge. Counting resumes 1,2,...
- Cascade of MODULUS 10 units -> MODULUS 6 tens, en=1 for 60 clks:
  - tens increments at each units 9->0;
  - state (5,9) has tens.co=1;
  - the next edge returns both digits to (0,0).

Source files
------------

// File: rtl/modn_counter_pkg.sv
// Shared constants and helpers for the modulo-N digit counters.
package modn_counter_pkg;

   // Width of one BCD-style digit and the two moduli used in time counters.
   localparam int DIGIT_W = 4;
   localparam int MOD_DEC = 10;
   localparam int MOD_SEX = 6;

   // Minimum number of bits needed to hold values 0..value-1.
   function automatic int clog2(input int value);
      int bits;
      bits = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            bits = i + 1;
         end
      end
      return bits;
   endfunction

endpackage : modn_counter_pkg

// File: rtl/modn_counter_cascade.sv
// 0..59 counter: a decade units digit feeding a modulo-6 tens digit.
module modn_counter_cascade
   import modn_counter_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   output logic [DIGIT_W-1:0] units,
   output logic [DIGIT_W-1:0] tens,
   output logic               co
);

   logic units_co;

   // Units digit advances on every system enable.
   modn_counter #(
      .MODULUS (MOD_DEC),
      .WIDTH   (DIGIT_W)
   ) u_units (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .count (units),
      .co    (units_co)
   );

   // Tens digit advances only on the units 9->0 wrap; its carry is the overall carry.
   modn_counter #(
      .MODULUS (MOD_SEX),
      .WIDTH   (DIGIT_W)
   ) u_tens (
      .clk   (clk),
      .rst   (rst),
      .en    (units_co),
      .count (tens),
      .co    (co)
   );

endmodule : modn_counter_cascade

// File: rtl/modn_counter.sv
// Modulo-N up-counter with count enable and combinational terminal-count carry.
// Interface: en is a qualify-only strobe with no back-pressure; every rising
// clk edge that samples en=1 advances count by exactly one step, and co flags
// the cycle in which that step will wrap count back to 0.
module modn_counter
   import modn_counter_pkg::*;
#(
   parameter int MODULUS = 10,
   parameter int WIDTH   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [WIDTH-1:0] count,
   output logic             co
);

   // Terminal value; fits in WIDTH bits because MODULUS <= 2**WIDTH.
   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

   // Reject moduli that cannot be represented or that make no sense.
   generate
      if (MODULUS < 2 || clog2(MODULUS) > WIDTH) begin : g_bad_modulus
         $error("modn_counter: MODULUS out of range for WIDTH");
      end
   endgenerate

   // Count state: async clear, enabled increment, wrap at or beyond the last value
   // so any out-of-range upset value recovers on the next enabled edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (en) begin
         if (count >= LAST) begin
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

   // Carry is only meaningful when the next edge actually wraps.
   assign co = en & (count == LAST);

endmodule : modn_counter

// File: tb/tb_modn_counter.sv
// Scoreboarded bench for the decade, modulo-6 and 0..59 cascade counters.
module tb_modn_counter;
  import modn_counter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic en10, en6, enc;
  always #5 clk = ~clk;

  logic [DIGIT_W-1:0] count10, count6, units, tens;
  logic               co10, co6, coc;

  modn_counter #(.MODULUS(MOD_DEC), .WIDTH(DIGIT_W)) dut10 (
    .clk(clk), .rst(rst), .en(en10), .count(count10), .co(co10));
  modn_counter #(.MODULUS(MOD_SEX), .WIDTH(DIGIT_W)) dut6 (
    .clk(clk), .rst(rst), .en(en6), .count(count6), .co(co6));
  modn_counter_cascade dutc (
    .clk(clk), .rst(rst), .en(enc), .units(units), .tens(tens), .co(coc));

  // ---------------- reference model / scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int m10 = 0, m6 = 0, mtot = 0;   // model values: digit counts and 0..59 total
  logic [4:0] exp10_q[$];
  logic [4:0] exp6_q[$];
  logic [8:0] expc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One cycle: drive inputs after the falling edge, record what the outputs
  // must show for this cycle, then advance the model across the next rising edge.
  task automatic cycle(input logic r, input logic e10, input logic e6, input logic ec);
    @(negedge clk);
    rst = r; en10 = e10; en6 = e6; enc = ec;
    if (!r) begin
      m10 = 0; m6 = 0; mtot = 0;
    end
    exp10_q.push_back({4'(m10), e10 && (m10 == MOD_DEC - 1)});
    exp6_q.push_back({4'(m6), e6 && (m6 == MOD_SEX - 1)});
    expc_q.push_back({4'(mtot / 10), 4'(mtot % 10), ec && (mtot == 59)});
    if (r) begin
      if (e10) m10 = (m10 + 1) % MOD_DEC;
      if (e6)  m6  = (m6 + 1) % MOD_SEX;
      if (ec)  mtot = (mtot + 1) % 60;
    end
  endtask

  // Advance the decade counter (others follow) until the model reaches target.
  task automatic run_until10(input int target);
    for (int i = 0; i < 20 && m10 != target; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  // Pull reset low between edges and confirm the clear is immediate.
  task automatic async_reset_mid;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_count10", count10, 0);
    check("async_co10", co10, 0);
    check("async_count6", count6, 0);
    check("async_units", units, 0);
    check("async_tens", tens, 0);
    check("async_coc", coc, 0);
    m10 = 0; m6 = 0; mtot = 0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [4:0] e5;
    logic [8:0] e9;
    forever begin
      @(negedge clk);
      #2;
      if (exp10_q.size() > 0) begin
        e5 = exp10_q.pop_front();
        check("count10", count10, e5[4:1]);
        check("co10", co10, e5[0]);
      end
      if (exp6_q.size() > 0) begin
        e5 = exp6_q.pop_front();
        check("count6", count6, e5[4:1]);
        check("co6", co6, e5[0]);
      end
      if (expc_q.size() > 0) begin
        e9 = expc_q.pop_front();
        check("tens", tens, e9[8:5]);
        check("units", units, e9[4:1]);
        check("coc", coc, e9[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; en10 = 1'b0; en6 = 1'b0; enc = 1'b0;
    #1;
    check("reset_count10", count10, 0);
    check("reset_co10", co10, 0);

    // Reset held with en high: everything stays 0.
    repeat (3) cycle(1'b0, 1'b1, 1'b1, 1'b1);
    // Release with en low: no movement until an enabled edge.
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    // Free run: decade 1..9,0,1,2 and modulo-6 1..5,0,1,2 with carries.
    repeat (12) cycle(1'b1, 1'b1, 1'b1, 1'b1);

    // Enable hold at 4, then at 9 (co must drop), then raise en at 9.
    run_until10(4);
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run_until10(9);
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);

    // Async reset mid-count at 7, then resume counting.
    run_until10(7);
    async_reset_mid();
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (4) cycle(1'b1, 1'b1, 1'b1, 1'b1);

    // Full cascade period from zero plus one edge back to (0,0).
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (61) cycle(1'b1, 1'b1, 1'b1, 1'b1);

    // Randomized enables with occasional synchronous-looking reset pulses.
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 39) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0));
    end

    // Drain: every pushed expectation must have been compared.
    repeat (2) @(negedge clk);
    #4;
    check("drain10", exp10_q.size(), 0);
    check("drain6", exp6_q.size(), 0);
    check("drainc", expc_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_modn_counter
